mul_sequencer: RTL and testbench



---
 rtl/mul_sequencer_pkg.sv | 26 ++
 rtl/mul_sequencer_if.sv | 37 +++
 rtl/mul_shift_add_core.sv | 51 +++++
 rtl/mul_sequencer.sv | 120 ++++++++++++
 tb/tb_mul_sequencer.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiply sequencer.
// - op_e    : command encodings carried on the op port (11 is reserved and behaves as MUL)
// - state_e : sequencer FSM states, also exported on the debug state output
// - is_long_op() : true for the 64-bit result commands that need two register writes
package mul_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_UMULL = 2'b01,
        OP_SMULL = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CALC  = 3'd1,
        S_FIN   = 3'd2,
        S_WB_LO = 3'd3,
        S_WB_HI = 3'd4
    } state_e;

    function automatic logic is_long_op(input logic [1:0] op);
        return (op == OP_UMULL) || (op == OP_SMULL);
    endfunction

endpackage

// File: rtl/mul_sequencer_if.sv
// Command / write-port bundle between the main FSM (master) and the
// multiply sequencer (slave).
//   start, op, a, b          : command from the main FSM; start is only looked at
//                              while the sequencer is idle, there is no ready
//                              signal -- the master must hold off while busy=1
//   busy                     : sequencer is working (every state except IDLE)
//   wr_en, wr_hi, wr_data    : register-file write request (RdLo when wr_hi=0,
//                              RdHi when wr_hi=1); the write is unconditional,
//                              the register file has no back-pressure
//   done                     : one-cycle pulse on the last write of a command
//   dbg_state                : current FSM state, for observation only
interface mul_sequencer_if
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             wr_en;
    logic             wr_hi;
    logic [WIDTH-1:0] wr_data;
    state_e           dbg_state;

    modport master (
        output start, op, a, b,
        input  busy, done, wr_en, wr_hi, wr_data, dbg_state
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, wr_en, wr_hi, wr_data, dbg_state
    );
endinterface

// File: rtl/mul_shift_add_core.sv
// Radix-2 shift-add datapath.
//   clk, reset : clock and synchronous active-high reset
//   load       : capture multiplicand/multiplier magnitudes, clear accumulator
//   step       : one iteration (conditional add into upper half, shift right)
//   negate     : replace the 2W-bit product with its two's complement
//   mcand_in   : multiplicand (already made non-negative by the sequencer)
//   mplier_in  : multiplier   (already made non-negative by the sequencer)
//   product    : 2W-bit result, valid after WIDTH steps (and optional negate)
module mul_shift_add_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               negate,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic [2*WIDTH-1:0] product
);
    // One spare top bit holds the carry out of the upper-half add; it is
    // shifted down on the same step, so it is always zero between steps.
    logic [2*WIDTH:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   upper_sum;

    always_comb begin
        upper_sum = acc[2*WIDTH:WIDTH] + (mplier[0] ? {1'b0, mcand} : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= mcand_in;
            mplier <= mplier_in;
        end else if (step) begin
            acc    <= {1'b0, upper_sum, acc[WIDTH-1:1]};
            mplier <= mplier >> 1;
        end else if (negate) begin
            // -0 is 0 in two's complement, so a zero magnitude stays zero.
            acc    <= {1'b0, -acc[2*WIDTH-1:0]};
        end
    end

    assign product = acc[2*WIDTH-1:0];
endmodule

// File: rtl/mul_sequencer.sv
// Multicycle sequencer for MUL / UMULL / SMULL on an iterative shift-add core.
//   clk, reset : clock and synchronous active-high reset
//   bus        : mul_sequencer_if slave (start/op/a/b in; busy, done,
//                wr_en, wr_hi, wr_data, dbg_state out)
// Flow: IDLE -> CALC (WIDTH cycles) -> FIN (sign fix) -> WB_LO -> [WB_HI] -> IDLE.
// SMULL is done on magnitudes; the sign is re-applied in FIN.
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic            clk,
    input  logic            reset,
    mul_sequencer_if.slave  bus
);
    state_e             state;
    state_e             state_nxt;
    logic [CNTW-1:0]    cnt;
    logic [1:0]         op_q;
    logic               neg_q;
    logic               is_smull;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               load;
    logic               step;
    logic               negate;
    logic               last_iter;
    logic [2*WIDTH-1:0] product;

    // Operand conditioning for the accepted command. The most negative value
    // maps onto itself, which read as unsigned is exactly its magnitude.
    assign is_smull = (bus.op == OP_SMULL);
    assign a_mag    = (is_smull && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag    = (is_smull && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign last_iter = (cnt == CNTW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_CALC;
            S_CALC:  if (last_iter) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_WB_LO;
            S_WB_LO: state_nxt = is_long_op(op_q) ? S_WB_HI : S_IDLE;
            S_WB_HI: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output / control decode: write port depends only on registered state
    // and product; start only feeds the load strobe into registers.
    always_comb begin
        load        = 1'b0;
        step        = 1'b0;
        negate      = 1'b0;
        bus.busy    = (state != S_IDLE);
        bus.done    = 1'b0;
        bus.wr_en   = 1'b0;
        bus.wr_hi   = 1'b0;
        bus.wr_data = '0;
        case (state)
            S_IDLE:  load = bus.start;
            S_CALC:  step = 1'b1;
            S_FIN:   negate = neg_q;
            S_WB_LO: begin
                bus.wr_en   = 1'b1;
                bus.wr_data = product[WIDTH-1:0];
                bus.done    = !is_long_op(op_q);
            end
            S_WB_HI: begin
                bus.wr_en   = 1'b1;
                bus.wr_hi   = 1'b1;
                bus.wr_data = product[2*WIDTH-1:WIDTH];
                bus.done    = 1'b1;
            end
            default: ;
        endcase
    end

    // Command latch and iteration counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            op_q  <= OP_MUL;
            neg_q <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            op_q  <= bus.op;
            neg_q <= is_smull && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
        end else if (step) begin
            cnt   <= cnt + 1'b1;
        end
    end

    assign bus.dbg_state = state;

    mul_shift_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .negate    (negate),
        .mcand_in  (a_mag),
        .mplier_in (b_mag),
        .product   (product)
    );
endmodule

// File: tb/tb_mul_sequencer.sv
module tb_mul_sequencer;
    import mul_sequencer_pkg::*;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    mul_sequencer_if #(.WIDTH(W)) bus ();

    mul_sequencer #(
        .WIDTH (W),
        .CNTW  (6)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference product from plain integer arithmetic.
    function automatic logic [63:0] ref_product(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [31:0]     lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 2'b10) return 64'(sa * sb);
        if (op == 2'b01) return 64'(ua * ub);
        lo = a * b;
        return {32'd0, lo};
    endfunction

    // One command, cycle-by-cycle checked. g1/g2: cycles in which a spurious
    // start is pulsed; rst_at: cycle in which reset is asserted (0 = none).
    task automatic run_op(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                          input int g1, input int g2, input int rst_at);
        logic [63:0] p;
        logic        lng;
        logic        exp_wr;
        int          last;
        p    = ref_product(op_i, a_i, b_i);
        lng  = (op_i == 2'b01) || (op_i == 2'b10);
        last = lng ? W + 3 : W + 2;

        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        @(posedge clk);

        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == g1 || c == g2) begin
                bus.start = 1'b1;
                bus.a     = $urandom;
                bus.b     = $urandom;
                bus.op    = 2'($urandom_range(0, 3));
            end else begin
                bus.start = 1'b0;
            end
            if (rst_at != 0 && c > rst_at) begin
                if (c == rst_at + 1) begin
                    reset = 1'b0;
                    check($sformatf("rst_busy_c%0d", c), 32'(bus.busy), 32'd0);
                end
                check($sformatf("rst_wr_en_c%0d", c), 32'(bus.wr_en), 32'd0);
                check($sformatf("rst_done_c%0d", c), 32'(bus.done), 32'd0);
            end else begin
                exp_wr = (c == W + 2) || (lng && c == W + 3);
                check($sformatf("busy_c%0d", c), 32'(bus.busy), 32'd1);
                check($sformatf("wr_en_c%0d", c), 32'(bus.wr_en), 32'(exp_wr));
                check($sformatf("done_c%0d", c), 32'(bus.done), 32'(c == last));
                if (exp_wr) begin
                    check($sformatf("wr_hi_c%0d", c), 32'(bus.wr_hi), 32'(c == W + 3));
                    check($sformatf("wr_data_c%0d", c), bus.wr_data,
                          (c == W + 3) ? p[63:32] : p[31:0]);
                end
            end
            if (rst_at != 0 && c == rst_at) reset = 1'b1;
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_hi", 32'(bus.wr_hi), 32'd0);
        check("rst_wr_data", bus.wr_data, 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
        reset = 1'b0;

        // Directed cases
        run_op(2'b00, 32'd7, 32'd6, 0, 0, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
        run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 0, 0, 0);
        run_op(2'b10, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
        run_op(2'b10, 32'd0, 32'h8000_0000, 0, 0, 0);
        run_op(2'b01, 32'h8000_0000, 32'd2, 0, 0, 0);
        run_op(2'b11, 32'hFFFF_FFFD, 32'd5, 0, 0, 0);
        // Spurious starts while busy, then an immediate follow-on command
        run_op(2'b00, 32'd7, 32'd6, 5, 20, 0);
        run_op(2'b10, 32'h1234_5678, 32'hFEDC_BA98, 0, 0, 0);
        // Reset during CALC, then a clean command
        run_op(2'b00, 32'd7, 32'd6, 0, 0, 10);
        run_op(2'b00, 32'd3, 32'd5, 0, 0, 0);

        // Randomized commands, some with spurious starts
        for (int i = 0; i < 24; i++) begin
            int g;
            g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : 0;
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), g, 0, 0);
        end

        @(negedge clk);
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
